key_sched_ctrl: RTL and testbench
=================================

# key_sched_ctrl

Controller that owns the cipher key register in front of `key_expansion` and sequences its 9-stage pipelined round-key generation. It accepts a new key through a valid/ready handshake and drives it to `key_expansion.key`. It holds that key stable for exactly the settle time of the `pipereg` chain, then asserts `keys_valid` to the round datapath once all 11 round keys reflect the same key. It refuses key changes while the datapath reports blocks in flight, so no block is ever encrypted with a mixed key set.

## Interface
- `KEY_W`, default 128: key width; bit 0 is the MSB, matching `[0:KEY_W-1]` ordering.
- `SETTLE`, default 9: number of pipeline registers in `key_expansion`. Legal range is 1..15.
- `clk` in 1: single clock; all state on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `key_in` in `[0:KEY_W-1]`: candidate cipher key.
- `key_valid` in 1: `key_in` is presented.
- `key_ready` out 1: a key is accepted this cycle when `key_valid && key_ready`.
- `key_clear` in 1: synchronous abort/invalidate. It has priority over everything except `rst`.
- `pipe_busy` in 1: the round datapath holds blocks using the current round keys.
- `key_out` out `[0:KEY_W-1]`: registered; connects to `key_expansion.key`.
- `keys_valid` out 1: registered; `roundkey_0..roundkey_10` are all consistent with `key_out`.
- `settle_cnt` out 4: registered settle counter, for debug.
- `key_gen` out 4: registered count of accepted keys, mod 16.

## Operation
- **FSM states:** IDLE, SETTLE, READY.
- **Reset (rst low):** state IDLE, `key_out`=0, `keys_valid`=0, `settle_cnt`=0, `key_gen`=0. `key_ready` is forced 0 while `rst` is low.
- **`key_ready` (combinational, not registered):**
  - 1 in IDLE when `key_clear`=0.
  - 1 in READY when `key_clear`=0 and `pipe_busy`=0.
  - 0 in SETTLE.
- **Accept** (`key_valid && key_ready`, in IDLE or READY):
  - `key_out` <= `key_in`, `settle_cnt` <= 0, `key_gen` <= `key_gen`+1 (15 wraps to 0).
  - `keys_valid` <= 0; state -> SETTLE.
- **SETTLE:**
  - `settle_cnt` increments each cycle.
  - When `settle_cnt` == SETTLE-1: state -> READY, `keys_valid` <= 1, `settle_cnt` holds.
  - `key_valid` and `pipe_busy` are ignored.
- **READY:**
  - `keys_valid` stays 1 until the next accept or clear.
  - `key_valid` with `pipe_busy`=1 stalls: no accept, `key_out` and `keys_valid` unchanged. The requester must hold `key_in` and `key_valid` stable until accepted.
- **`key_clear`=1 (any state):** state -> IDLE, `keys_valid` <= 0, `key_out` <= 0, `settle_cnt` <= 0; `key_gen` unchanged. A simultaneous `key_valid` is not accepted because `key_ready` is 0.
- `key_out` changes only on accept or clear. It never changes in SETTLE, so the `key_expansion` pipeline always fills with a single key.

## Timing
- **Capture:** accept at edge E0 puts the new key on `key_out` after E0. `roundkey_1` is valid after E0; `roundkey_k` is valid after edge E(k-1).
- **Settle latency:** `keys_valid` rises after edge E(SETTLE), which is E9 by default. That is exactly SETTLE cycles after the capture edge, the same edge at which `roundkey_10` becomes valid.
- **Drop:** `keys_valid` falls after the accept or clear edge. There is no cycle in which `keys_valid`=1 with a partially propagated key.
- **Back-to-back keys:** the minimum accept-to-accept spacing is SETTLE+1 cycles; the earliest re-accept is the first READY cycle.
- **Reset mid-SETTLE:** immediate asynchronous return to reset values. The downstream `pipereg` contents are irrelevant because `keys_valid`=0.
- **`pipe_busy`** affects `key_ready` combinationally in the same cycle. There is no extra latency.

## Test plan
- **Basic load:** after reset, present `key_in`=000102030405060708090a0b0c0d0e0f with `key_valid`=1 for 1 cycle.
  - `key_ready` is 1 and the key is accepted.
  - `key_out` matches next cycle.
  - `keys_valid` rises exactly 9 cycles after the accept edge.
  - `roundkey_10` equals 13111d7fe3944a17f307a78b4d2b30c5 at that point.
  - `key_gen`=1.
- **Busy stall:** in READY, hold `pipe_busy`=1 and `key_valid`=1 with a new key for 5 cycles.
  - `key_ready`=0 throughout; `key_out` and `keys_valid`=1 unchanged.
  - Drop `pipe_busy`: accepted that cycle, and `keys_valid` falls the next cycle.
- **SETTLE ignores requests:** assert `key_valid` with key B during SETTLE cycles 2-6.
  - `key_ready`=0; `key_out` stays key A; `settle_cnt` counts 0..8 monotonically.
- **Clear:**
  - Assert `key_clear` at `settle_cnt`=4 together with `key_valid`: state IDLE, `key_out`=0, `keys_valid`=0, no accept, `key_gen` unchanged.
  - Repeat with `key_clear` in READY: same result.
- **Async reset:** drop `rst` mid-SETTLE, between clock edges.
  - All outputs go to 0 immediately, without waiting for a clock; `key_ready` is 0 while `rst` is low.
  - After release, a normal load succeeds with 9-cycle latency.
- **Back-to-back and wrap:** 17 consecutive loads, each offered as soon as `key_ready`=1.
  - Accepts are spaced exactly 10 cycles apart.
  - `key_gen` wraps 15 -> 0 -> 1.
  - Run again with SETTLE=1: `keys_valid` rises 1 cycle after accept.

Source files
------------

// File: rtl/key_sched_ctrl.sv
// key_sched_ctrl: owns the cipher key feeding key_expansion and flags when all
// round keys have settled through its pipeline, blocking key changes while busy.
module key_sched_ctrl #(
    parameter int KEY_W  = 128,
    parameter int SETTLE = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [0:KEY_W-1] key_in,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic             key_clear,
    input  logic             pipe_busy,
    output logic [0:KEY_W-1] key_out,
    output logic             keys_valid,
    output logic [3:0]       settle_cnt,
    output logic [3:0]       key_gen
);
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_READY} state_t;

    localparam logic [3:0] LAST = 4'(SETTLE - 1);

    state_t           state_q, state_d;
    logic [0:KEY_W-1] key_q, key_d;
    logic             kv_q, kv_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       gen_q, gen_d;
    logic             accept;

    // rst gates ready directly so no key is taken while reset is held
    assign key_ready = rst && !key_clear &&
                       (state_q == S_IDLE || (state_q == S_READY && !pipe_busy));
    assign accept    = key_valid && key_ready;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        kv_d    = kv_q;
        cnt_d   = cnt_q;
        gen_d   = gen_q;
        if (key_clear) begin
            state_d = S_IDLE;
            key_d   = '0;
            kv_d    = 1'b0;
            cnt_d   = '0;
        end else if (accept) begin
            state_d = S_SETTLE;
            key_d   = key_in;
            kv_d    = 1'b0;
            cnt_d   = '0;
            gen_d   = gen_q + 4'd1;
        end else if (state_q == S_SETTLE) begin
            if (cnt_q == LAST) begin
                state_d = S_READY;
                kv_d    = 1'b1;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            key_q   <= '0;
            kv_q    <= 1'b0;
            cnt_q   <= '0;
            gen_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            kv_q    <= kv_d;
            cnt_q   <= cnt_d;
            gen_q   <= gen_d;
        end
    end

    assign key_out    = key_q;
    assign keys_valid = kv_q;
    assign settle_cnt = cnt_q;
    assign key_gen    = gen_q;
endmodule

// File: tb/tb_key_sched_ctrl.sv
// tb_key_sched_ctrl: drives SETTLE=9 and SETTLE=1 controllers with shared stimulus
// and compares both against an age-since-accept reference model.
module tb_key_sched_ctrl;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_valid = 1'b0;
    logic         key_clear = 1'b0;
    logic         pipe_busy = 1'b0;
    logic [0:127] key_in = '0;
    logic         kr[2];
    logic         kvo[2];
    logic [0:127] ko[2];
    logic [3:0]   sc[2];
    logic [3:0]   kg[2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit           hk[2];
    int           age[2];
    logic [0:127] mkey[2];
    int           mgen[2];

    always #5 clk = ~clk;

    key_sched_ctrl #(.KEY_W(128), .SETTLE(9)) u0 (
        .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(kr[0]),
        .key_clear(key_clear), .pipe_busy(pipe_busy), .key_out(ko[0]), .keys_valid(kvo[0]),
        .settle_cnt(sc[0]), .key_gen(kg[0])
    );
    key_sched_ctrl #(.KEY_W(128), .SETTLE(1)) u1 (
        .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(kr[1]),
        .key_clear(key_clear), .pipe_busy(pipe_busy), .key_out(ko[1]), .keys_valid(kvo[1]),
        .settle_cnt(sc[1]), .key_gen(kg[1])
    );

    function automatic int sv(int d);
        return d == 0 ? 9 : 1;
    endfunction

    function automatic logic exp_rdy(int d);
        return rst && !key_clear && (!hk[d] || (age[d] >= sv(d) && !pipe_busy));
    endfunction

    function automatic logic [0:127] rkey();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            hk[d] = 1'b0;
            age[d] = 0;
            mkey[d] = '0;
            mgen[d] = 0;
        end
    endtask

    task automatic check_regs();
        for (int d = 0; d < 2; d++) begin
            chk(d ? "key_out_s1" : "key_out", 128'(ko[d]), 128'(mkey[d]));
            chk(d ? "keys_valid_s1" : "keys_valid", 128'(kvo[d]), 128'(hk[d] && age[d] >= sv(d)));
            chk(d ? "settle_cnt_s1" : "settle_cnt", 128'(sc[d]),
                128'(hk[d] ? (age[d] >= sv(d) ? sv(d) - 1 : age[d]) : 0));
            chk(d ? "key_gen_s1" : "key_gen", 128'(kg[d]), 128'(mgen[d]));
        end
    endtask

    // called at a falling edge: apply inputs, check ready, clock, check state
    task automatic cycle(input logic v, input logic [0:127] k, input logic c, input logic b);
        logic acc[2];
        key_valid = v;
        key_in = k;
        key_clear = c;
        pipe_busy = b;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk(d ? "key_ready_s1" : "key_ready", 128'(kr[d]), 128'(exp_rdy(d)));
            acc[d] = v && exp_rdy(d);
        end
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (c) begin
                hk[d] = 1'b0;
                age[d] = 0;
                mkey[d] = '0;
            end else if (acc[d]) begin
                hk[d] = 1'b1;
                age[d] = 0;
                mkey[d] = k;
                mgen[d] = (mgen[d] + 1) % 16;
            end else if (hk[d] && age[d] < sv(d)) begin
                age[d]++;
            end
        end
        @(negedge clk);
        check_regs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [0:127] ka;
        logic [0:127] kb;
        logic [0:127] bk;
        logic [3:0]   pg;
        int           n;
        int           last;
        ka = 128'h000102030405060708090a0b0c0d0e0f;
        kb = rkey();
        model_reset();

        #1 rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) chk("reset_ready", 128'(kr[d]), 128'd0);
        check_regs();
        @(negedge clk);
        rst = 1'b1;

        // basic load, with key B offered during settle cycles 2-6
        cycle(1'b1, ka, 1'b0, 1'b0);
        idle(1);
        for (int i = 0; i < 5; i++) cycle(1'b1, kb, 1'b0, 1'b0);
        idle(3);
        chk("load_kv_edge9", 128'(kvo[0]), 128'd1);
        chk("load_gen", 128'(kg[0]), 128'd1);

        // busy stall then release
        for (int i = 0; i < 5; i++) cycle(1'b1, kb, 1'b0, 1'b1);
        cycle(1'b1, kb, 1'b0, 1'b0);
        chk("stall_release_kv", 128'(kvo[0]), 128'd0);

        // clear mid-settle alongside a request
        idle(4);
        chk("clear_cnt4", 128'(sc[0]), 128'd4);
        cycle(1'b1, rkey(), 1'b1, 1'b0);
        idle(1);

        // clear in ready
        cycle(1'b1, ka, 1'b0, 1'b0);
        idle(10);
        cycle(1'b1, rkey(), 1'b1, 1'b0);
        idle(1);

        // async reset between edges mid-settle
        cycle(1'b1, kb, 1'b0, 1'b0);
        idle(3);
        #2 rst = 1'b0;
        #1;
        model_reset();
        for (int d = 0; d < 2; d++) chk("areset_ready", 128'(kr[d]), 128'd0);
        check_regs();
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b1, ka, 1'b0, 1'b0);
        idle(9);

        // back-to-back loads through the key_gen wrap
        bk = rkey();
        pg = kg[0];
        n = 0;
        last = 0;
        for (int t = 0; t < 400 && n < 17; t++) begin
            cycle(1'b1, bk, 1'b0, 1'b0);
            if (kg[0] !== pg) begin
                if (n > 0) chk("b2b_spacing", 128'(cyc - last), 128'd10);
                n++;
                last = cyc;
                pg = kg[0];
                bk = rkey();
            end
        end
        chk("b2b_count", 128'(n), 128'd17);

        // random traffic
        for (int t = 0; t < 400; t++)
            cycle(1'($urandom_range(0, 1)), rkey(), 1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 2) == 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
